// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with valid/ready handshakes on both sides.
// The winning channel comes from an explicit select (MODE 0) or a round-robin arbiter (MODE 1).
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SW-1:0]      sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  output logic               sel_err
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [SW-1:0]    rr_ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [SW-1:0]    src_r;
  logic             sel_err_r;

  logic             sel_ok_s;
  logic             sel_hit_s;
  logic [N-1:0]     rot_s;
  logic [SW:0]      sum_s;
  logic             rr_hit_s;
  logic [SW-1:0]    rr_grant_s;
  logic [SW-1:0]    grant_s;
  logic             grant_valid_s;
  logic             space_s;
  logic             accept_s;
  logic [WIDTH-1:0] grant_data_s;

  // Select-mode grant: sel must name an existing channel that is presenting a word
  always_comb begin
    sel_ok_s  = 1'b0;
    sel_hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_ok_s  = sel_ok_s | (sel == SW'(i));
      sel_hit_s = sel_hit_s | ((sel == SW'(i)) & in_valid[i]);
    end
  end

  // Round-robin grant: rotate requests so rr_ptr sits at bit 0, take the first set bit
  always_comb begin
    rot_s      = N'({in_valid, in_valid} >> rr_ptr_r);
    rr_hit_s   = 1'b0;
    sum_s      = {(SW+1){1'b0}};
    rr_grant_s = {SW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!rr_hit_s && rot_s[i]) begin
        rr_hit_s = 1'b1;
        sum_s    = {1'b0, rr_ptr_r} + (SW+1)'(i);
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end
    if (sum_s >= (SW+1)'(N)) begin
      rr_grant_s = SW'(sum_s - (SW+1)'(N));
    end else begin
      rr_grant_s = SW'(sum_s);
    end
  end

  // Final grant, handshake and the data word of the winning channel
  always_comb begin
    if (MODE == 1) begin
      grant_s       = rr_grant_s;
      grant_valid_s = rr_hit_s;
    end else begin
      grant_s       = sel;
      grant_valid_s = sel_ok_s & sel_hit_s;
    end
    space_s      = (state_r == EMPTY) | out_ready;
    accept_s     = grant_valid_s & space_s;
    grant_data_s = {WIDTH{1'b0}};
    in_ready     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      grant_data_s = grant_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s == SW'(i)}});
      in_ready[i]  = accept_s & (grant_s == SW'(i));
    end
  end

  // Output stage occupancy: a fill always wins over a drain
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_s = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State, output word, source index, select error flag and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= EMPTY;
      data_r    <= {WIDTH{1'b0}};
      src_r     <= {SW{1'b0}};
      sel_err_r <= 1'b0;
      rr_ptr_r  <= {SW{1'b0}};
    end else begin
      state_r   <= state_s;
      sel_err_r <= (MODE == 0) ? ~sel_ok_s : 1'b0;
      if (accept_s) begin
        data_r <= grant_data_s;
        src_r  <= grant_s;
      end else begin
        data_r <= data_r;
        src_r  <= src_r;
      end
      if ((MODE == 1) && accept_s) begin
        rr_ptr_r <= (grant_s == SW'(N-1)) ? {SW{1'b0}} : grant_s + SW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_src   = src_r;
  assign sel_err   = sel_err_r;

endmodule
